uart_tx_pulsed: RTL and testbench
=================================

// Module: uart_tx_pulsed
// PURPOSE
//   UART transmitter that sends one 8N1-style frame per one-shot send request.
//   Consumes the single/two-cycle pulse produced by the switch pulse generator,
//   latches the parallel byte and serializes it LSB-first on tx.
//   Sits between the user-input pulse logic and the board TX pin.
// PARAMETERS
//   CLKS_PER_BIT  868  clk cycles per bit (100 MHz / 115200); legal range >= 2
//   DATA_BITS     8    data bits per frame; legal range 5..8
// PORTS
//   clk      in   1          system clock; all logic on its rising edge
//   rst_n    in   1          asynchronous reset, active low
//   start    in   1          send request; sampled only in IDLE
//   data_in  in   DATA_BITS  byte to send; latched in the cycle start is accepted
//   tx       out  1          serial line; idle high
//   busy     out  1          high while a frame is in progress
//   done     out  1          one-cycle pulse after the stop bit completes
// BEHAVIOUR
//   Clocking and reset: one clock (clk).
//   - rst_n=0 asynchronously forces: state=IDLE, tx=1, busy=0, done=0,
//     baud counter=0, bit index=0, shift register=0.
//   - Reset during a frame abandons it; tx returns high immediately.
//   - No partial frame resumes after release.
//   States: IDLE -> START -> DATA -> STOP -> IDLE. All outputs are registered.
//   IDLE: tx=1, busy=0.
//     - If start=1: latch data_in into the shift register, go to START.
//     - tx falls on the next edge, so start-to-line latency is 1 cycle.
//   START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index=0.
//   DATA:
//     - tx = shift[0] for CLKS_PER_BIT cycles; shift right, bit index+1.
//     - After bit DATA_BITS-1, go to STOP.
//   STOP:
//     - tx=1 for CLKS_PER_BIT cycles.
//     - On the last cycle, next state=IDLE and done<=1.
//   busy = 1 in START, DATA and STOP.
//   done = 1 for exactly one cycle: the first IDLE cycle after STOP.
//   Frame length: (DATA_BITS+2)*CLKS_PER_BIT cycles from the first tx-low cycle.
//   Baud counter:
//     - Width $clog2(CLKS_PER_BIT).
//     - Counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary.
//     - Never free-runs in IDLE; it is held at 0.
//   start outside IDLE is ignored; there is no queueing.
//     - data_in changes mid-frame do not affect the frame in progress.
//   start=1 in the done cycle is accepted, so frames can run back to back.
//     - In that case the stop bit is extended by exactly 1 cycle (the done/IDLE cycle).
//   start held high across several IDLE cycles: only the first is accepted.
//     - Later cycles fall outside IDLE.
//     - Upstream guarantees start deasserts within 2 cycles.
// TESTING (CLKS_PER_BIT=4, DATA_BITS=8)
//   1. Reset: rst_n=0 for 3 cycles -> tx=1, busy=0, done=0 throughout.
//   2. Single frame: start pulse with data_in=8'hA5.
//      -> tx=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each.
//      -> stop=1 for 4 cycles, then done=1 for 1 cycle; busy high for 40 cycles.
//   3. Ignored request: second start with data_in=8'hFF during DATA of an 8'hA5 frame.
//      -> 8'hA5 is transmitted intact; exactly one done pulse.
//   4. Back to back: start with data_in=8'h3C in the done cycle.
//      -> tx low on the next edge, 8'h3C is sent correctly.
//      -> total tx-high gap between frames is 5 cycles.
//   5. Reset mid-frame: rst_n=0 during data bit 3.
//      -> tx=1 and busy=0 before the next clk edge.
//      -> after release, start with data_in=8'h00 gives a clean 40-cycle frame.
//   6. Two-cycle start pulse with data_in=8'h81.
//      -> exactly one frame and exactly one done pulse.

Source files
------------

// File: rtl/uart_tx_pulsed.sv
// uart_tx_pulsed: one-shot-triggered 8N1-style UART transmitter, LSB first, registered outputs
module uart_tx_pulsed #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] data_in,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d, busy_q, busy_d, done_q, done_d;
   logic                 last;
   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;
   assign last = cnt_q == CW'(CLKS_PER_BIT - 1);
   // next state; tx/busy are derived from the next state so the line moves on the same edge as the state
   always_comb begin
      state_d = state_q;
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (start) begin
               state_d = START;
               shift_d = data_in;
            end
         end
         START: if (last) begin
            state_d = DATA;
            idx_d   = '0;
         end
         DATA: if (last) begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IW'(DATA_BITS - 1)) state_d = STOP;
         end
         default: if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      endcase
      tx_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
      busy_d = state_d != IDLE;
   end
   // state and output registers; reset abandons any frame and idles the line high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_pulsed.sv
// tb_uart_tx_pulsed: directed bench for uart_tx_pulsed with CLKS_PER_BIT=4, DATA_BITS=8
module tb_uart_tx_pulsed;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       tx, busy, done;
   int         total = 0;
   int         bad = 0;

   uart_tx_pulsed #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
      .tx(tx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // expected line level for cycle k (0..39) of a frame carrying d
   function automatic logic exp_tx(input logic [7:0] d, input int k);
      int b = k / 4;
      return (b == 0) ? 1'b0 : (b > 8) ? 1'b1 : d[b-1];
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      repeat (3) begin
         @(negedge clk);
         total++;
         if ({tx, busy, done} !== 3'b100) begin
            bad++;
            $display("FAIL reset tx/busy/done=%b exp=100", {tx, busy, done});
         end
      end
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      start = 1'b1;
      data_in = 8'hA5;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         total++;
         if ({tx, busy, done} !== {exp_tx(8'hA5, k), 2'b10}) begin
            bad++;
            $display("FAIL single k=%0d tx/busy/done=%b exp=%b", k, {tx, busy, done}, {exp_tx(8'hA5, k), 2'b10});
         end
         @(negedge clk);
      end
      total++;
      if ({tx, busy, done} !== 3'b101) begin
         bad++;
         $display("FAIL single_done tx/busy/done=%b exp=101", {tx, busy, done});
      end
      @(negedge clk);
      total++;
      if ({tx, busy, done} !== 3'b100) begin
         bad++;
         $display("FAIL single_after tx/busy/done=%b exp=100", {tx, busy, done});
      end
   endtask

   task automatic test_ignored();
      start = 1'b1;
      data_in = 8'hA5;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         start = (k == 12);
         if (k == 12) data_in = 8'hFF;
         total++;
         if ({tx, busy, done} !== {exp_tx(8'hA5, k), 2'b10}) begin
            bad++;
            $display("FAIL ignored k=%0d tx/busy/done=%b exp=%b", k, {tx, busy, done}, {exp_tx(8'hA5, k), 2'b10});
         end
         @(negedge clk);
      end
      start = 1'b0;
      total++;
      if ({tx, busy, done} !== 3'b101) begin
         bad++;
         $display("FAIL ignored_done tx/busy/done=%b exp=101", {tx, busy, done});
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         total++;
         if ({tx, busy, done} !== 3'b100) begin
            bad++;
            $display("FAIL ignored_idle k=%0d tx/busy/done=%b exp=100", k, {tx, busy, done});
         end
      end
   endtask

   task automatic test_back_to_back();
      int gap = 0;
      start = 1'b1;
      data_in = 8'h5A;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (k >= 32 && tx === 1'b1) gap++;
         if (k >= 32 && tx !== 1'b1) gap = 0;
         total++;
         if (tx !== exp_tx(8'h5A, k)) begin
            bad++;
            $display("FAIL b2b_first k=%0d tx=%b exp=%b", k, tx, exp_tx(8'h5A, k));
         end
         @(negedge clk);
      end
      total++;
      if ({tx, done} !== 2'b11) begin
         bad++;
         $display("FAIL b2b_done tx/done=%b exp=11", {tx, done});
      end
      gap++;
      start = 1'b1;
      data_in = 8'h3C;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (gap !== 5) begin
         bad++;
         $display("FAIL b2b_gap gap=%0d exp=5", gap);
      end
      for (int k = 0; k < 40; k++) begin
         total++;
         if ({tx, busy, done} !== {exp_tx(8'h3C, k), 2'b10}) begin
            bad++;
            $display("FAIL b2b_second k=%0d tx/busy/done=%b exp=%b", k, {tx, busy, done}, {exp_tx(8'h3C, k), 2'b10});
         end
         @(negedge clk);
      end
      total++;
      if ({tx, busy, done} !== 3'b101) begin
         bad++;
         $display("FAIL b2b_done2 tx/busy/done=%b exp=101", {tx, busy, done});
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      data_in = 8'hF7;
      @(negedge clk);
      start = 1'b0;
      repeat (17) @(negedge clk);
      total++;
      if ({tx, busy} !== {exp_tx(8'hF7, 17), 1'b1}) begin
         bad++;
         $display("FAIL mid_pre tx/busy=%b exp=%b", {tx, busy}, {exp_tx(8'hF7, 17), 1'b1});
      end
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({tx, busy, done} !== 3'b100) begin
         bad++;
         $display("FAIL mid_async tx/busy/done=%b exp=100", {tx, busy, done});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         total++;
         if ({tx, busy, done} !== 3'b100) begin
            bad++;
            $display("FAIL mid_idle tx/busy/done=%b exp=100", {tx, busy, done});
         end
      end
      start = 1'b1;
      data_in = 8'h00;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         total++;
         if ({tx, busy, done} !== {exp_tx(8'h00, k), 2'b10}) begin
            bad++;
            $display("FAIL mid_frame k=%0d tx/busy/done=%b exp=%b", k, {tx, busy, done}, {exp_tx(8'h00, k), 2'b10});
         end
         @(negedge clk);
      end
      total++;
      if ({tx, busy, done} !== 3'b101) begin
         bad++;
         $display("FAIL mid_done tx/busy/done=%b exp=101", {tx, busy, done});
      end
      @(negedge clk);
   endtask

   task automatic test_two_cycle();
      start = 1'b1;
      data_in = 8'h81;
      @(negedge clk);
      for (int k = 0; k < 40; k++) begin
         if (k == 1) start = 1'b0;
         total++;
         if ({tx, busy, done} !== {exp_tx(8'h81, k), 2'b10}) begin
            bad++;
            $display("FAIL two_cycle k=%0d tx/busy/done=%b exp=%b", k, {tx, busy, done}, {exp_tx(8'h81, k), 2'b10});
         end
         @(negedge clk);
      end
      total++;
      if ({tx, busy, done} !== 3'b101) begin
         bad++;
         $display("FAIL two_cycle_done tx/busy/done=%b exp=101", {tx, busy, done});
      end
      for (int k = 0; k < 45; k++) begin
         @(negedge clk);
         total++;
         if ({tx, busy, done} !== 3'b100) begin
            bad++;
            $display("FAIL two_cycle_idle k=%0d tx/busy/done=%b exp=100", k, {tx, busy, done});
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_ignored();
      test_back_to_back();
      test_reset_mid();
      test_two_cycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
